ot_board_tx: RTL and testbench
==============================

# ot_board_tx

Synthesizable stimulus transmitter for the OT board-game evaluator. A host loads an 8×8 board (per-row cell mask and bomb mask) and a list of hit coordinates, then pulses `start`. The block drives the evaluator's two-phase input protocol (`in`/`bomb` under `in_valid1`, then `hit` under `in_valid2`), waits for the evaluator's `out_valid`/`out` response, and returns the captured score or a timeout flag to the host. It replaces the behavioural pattern driver on FPGA/emulation builds and sits directly between the host register interface and the evaluator.

## Interface
- `MAX_HITS`, default 16: depth of the hit buffer, 1..32.
- `TIMEOUT`, default 1000: maximum WAIT cycles without `out_valid` before abort; must be at least 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `row_we` input 1: host write to the board row selected by `row_addr`.
- `row_addr` input 3: row index 0..7.
- `row_in` input 8: cell mask for that row.
- `row_bomb` input 8: bomb mask for that row.
- `hit_we` input 1: push `hit_data` into the hit buffer.
- `hit_data` input 6: cell index, {row[2:0], col[2:0]}.
- `hit_clr` input 1: empty the hit buffer.
- `start` input 1: begin a transfer.
- `in` output 8: row cell mask to the evaluator.
- `bomb` output 8: row bomb mask to the evaluator.
- `in_valid1` output 1: phase-1 valid.
- `hit` output 6: hit index to the evaluator.
- `in_valid2` output 1: phase-2 valid.
- `out_valid` input 1: evaluator result valid.
- `out` input 7: evaluator score.
- `busy` output 1: transfer in progress.
- `done` output 1: one-cycle completion pulse.
- `result` output 7: last captured score.
- `timeout_err` output 1: the last transfer timed out.
- `hit_cnt` output 6: number of entries in the hit buffer.
- `hit_full` output 1: `hit_cnt == MAX_HITS`.

## Operation
- **FSM states:** IDLE → SEND1 → GAP → SEND2 → WAIT → IDLE.
- **IDLE:**
  - `start` with `hit_cnt >= 1` → SEND1. On that edge `timeout_err` clears and the row and hit counters are set to 0.
  - `start` with `hit_cnt == 0` is ignored; the block stays in IDLE.
- **SEND1:** `in_valid1 = 1` for exactly 8 cycles, presenting rows 0..7 in order on `in`/`bomb`. Then → GAP.
- **GAP:** exactly 1 cycle with all valids low. Then → SEND2.
- **SEND2:** `in_valid2 = 1` for exactly `hit_cnt` cycles, presenting buffer entries in push order. Then → WAIT.
- **WAIT:**
  - First `out_valid = 1` → capture `out` into `result`, pulse `done`, → IDLE.
  - If `out_valid` stays low for `TIMEOUT` consecutive WAIT cycles → `result = 0`, `timeout_err = 1`, pulse `done`, → IDLE.
- **DUT-facing data outputs:** `in`, `bomb` and `hit` are 0 whenever their valid is low. All DUT-facing outputs are registered.
- **Board registers:** writable only in IDLE; `row_we` while `busy` is ignored.
- **Hit buffer:**
  - `hit_we` is ignored when `busy` or `hit_full`.
  - `hit_clr` is ignored when `busy`.
  - If `hit_clr` and `hit_we` occur in the same cycle, clear wins.
  - The buffer contents survive a transfer and can be replayed by another `start`.
- **Ignored events:**
  - `out_valid` outside WAIT, including during SEND phases.
  - `start` while `busy`.
- **Host outputs:**
  - `busy = 1` in every state except IDLE.
  - `timeout_err` is sticky until the next accepted `start`.
  - `result` holds its value until the next completion.

## Timing
- **Reset:** all outputs 0, FSM in IDLE, board registers 0, `hit_cnt` 0. Reset mid-transfer aborts immediately; `in_valid1`/`in_valid2` drop asynchronously and no `done` is produced.
- **Transfer timeline**, with `start` sampled at edge T and N = `hit_cnt`:
  - `busy` = 1 from T+1.
  - `in_valid1` = 1 in cycles T+1..T+8, row k in cycle T+1+k.
  - Cycle T+9 is the GAP.
  - `in_valid2` = 1 in cycles T+10..T+9+N.
  - WAIT starts at cycle T+10+N.
- **Response:** `out_valid` sampled high at edge W → `result`/`done` valid in cycle W+1, `busy` = 0 in W+1. A new `start` is accepted in W+1.
- **Timeout:** `done` and `timeout_err` appear in cycle T+10+N+TIMEOUT.
- **Minimum transfer:** `out_valid` in the first WAIT cycle gives `done` at T+11+N.
- **Counter widths:** wait counter ⌈log2(TIMEOUT+1)⌉ bits; row counter 3 bits; hit pointer 5 bits.

## Test plan
- **Basic transfer:** load rows r with `in` = 8'hFF>>r and `bomb` = 8'h01<<r; push hits 0, 9, 63; `start`.
  - Required: 8 `in_valid1` cycles with row 3 = FF>>3 / 08, 1 gap, `in_valid2` carrying 0, 9, 63.
  - Model returns `out` = 7'd42 two cycles into WAIT → `result` = 42, `done` pulse at T+15, `busy` low.
- **Timeout:** `TIMEOUT` = 20, one hit, `out_valid` never asserted → `done` and `timeout_err` at T+31, `result` = 0. Next `start` clears `timeout_err`.
- **Buffer full:** push 17 hits with `MAX_HITS` = 16 → `hit_cnt` = 16, `hit_full` = 1, 17th entry dropped. `start` → 16 `in_valid2` cycles.
- **Empty buffer and ignored events:**
  - `start` with `hit_cnt` = 0 → no activity.
  - `out_valid` pulsed during SEND1 → ignored; result comes only from the WAIT response.
  - `start`, `row_we` and `hit_we` while `busy` → no effect on outputs or stored data.
- **Reset mid-SEND2:** assert `rst_n` = 0 during `in_valid2` → all outputs 0 immediately, `hit_cnt` = 0, no `done`.
- **Clear/push collision and replay:**
  - `hit_clr` and `hit_we` in the same cycle → `hit_cnt` = 0.
  - Two back-to-back `start`s with an unchanged buffer → identical `in_valid2` sequences.

Source files
------------

// File: rtl/ot_board_tx_if.sv
// Evaluator-side bus of the OT board transmitter: two-phase stimulus out, scored response back.
interface ot_board_tx_if;
  logic [7:0] in;
  logic [7:0] bomb;
  logic       in_valid1;
  logic [5:0] hit;
  logic       in_valid2;
  logic       out_valid;
  logic [6:0] out;

  modport master (
    output in, bomb, in_valid1, hit, in_valid2,
    input  out_valid, out
  );

  modport slave (
    input  in, bomb, in_valid1, hit, in_valid2,
    output out_valid, out
  );
endinterface

// File: rtl/ot_board_tx.sv
// Stimulus transmitter for the OT evaluator: streams the 8x8 board, then the hit list,
// and returns the evaluator's score (or a timeout flag) to the host.
module ot_board_tx #(
  parameter int unsigned MAX_HITS = 16,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            row_we,
  input  logic [2:0]      row_addr,
  input  logic [7:0]      row_in,
  input  logic [7:0]      row_bomb,
  input  logic            hit_we,
  input  logic [5:0]      hit_data,
  input  logic            hit_clr,
  input  logic            start,
  ot_board_tx_if.master   ev,
  output logic            busy,
  output logic            done,
  output logic [6:0]      result,
  output logic            timeout_err,
  output logic [5:0]      hit_cnt,
  output logic            hit_full
);

  localparam int unsigned WW    = $clog2(TIMEOUT + 1);
  localparam int unsigned AW    = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PW    = 5;
  localparam int unsigned CW    = 6;

  typedef enum logic [2:0] {S_IDLE, S_SEND1, S_GAP, S_SEND2, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [7:0]      in_q, in_d, bomb_q, bomb_d;
  logic            iv1_q, iv1_d, iv2_q, iv2_d;
  logic [5:0]      hit_q, hit_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [6:0]      result_q, result_d;
  logic            terr_q, terr_d;
  logic [CW-1:0]   hit_cnt_q, hit_cnt_d;
  logic            hit_full_q, hit_full_d;
  logic            mem_we, board_we;

  logic [7:0]      board_in_q   [8];
  logic [7:0]      board_bomb_q [8];
  logic [5:0]      hit_mem_q    [DEPTH];

  logic [2:0]      row_nxt;
  logic [PW-1:0]   ptr_nxt;

  assign row_nxt = row_q + 3'd1;
  assign ptr_nxt = ptr_q + PW'(1);

  // Transfer sequencer; DUT-facing outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    in_d     = 8'd0;
    bomb_d   = 8'd0;
    iv1_d    = 1'b0;
    hit_d    = 6'd0;
    iv2_d    = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    terr_d   = terr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && (hit_cnt_q != CW'(0))) begin
          state_d = S_SEND1;
          row_d   = 3'd0;
          ptr_d   = PW'(0);
          terr_d  = 1'b0;
          iv1_d   = 1'b1;
          in_d    = board_in_q[0];
          bomb_d  = board_bomb_q[0];
        end
      end
      S_SEND1: begin
        if (row_q == 3'd7) begin
          state_d = S_GAP;
        end else begin
          row_d  = row_nxt;
          iv1_d  = 1'b1;
          in_d   = board_in_q[row_nxt];
          bomb_d = board_bomb_q[row_nxt];
        end
      end
      S_GAP: begin
        state_d = S_SEND2;
        ptr_d   = PW'(0);
        iv2_d   = 1'b1;
        hit_d   = hit_mem_q[0];
      end
      S_SEND2: begin
        if ((CW'(ptr_q) + CW'(1)) == hit_cnt_q) begin
          state_d = S_WAIT;
          wcnt_d  = WW'(0);
        end else begin
          ptr_d = ptr_nxt;
          iv2_d = 1'b1;
          hit_d = hit_mem_q[AW'(ptr_nxt)];
        end
      end
      S_WAIT: begin
        if (ev.out_valid) begin
          result_d = ev.out;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
          result_d = 7'd0;
          terr_d   = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Host-side storage is only writable while idle; clear beats push.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    mem_we    = 1'b0;
    board_we  = row_we && (state_q == S_IDLE);
    if (state_q == S_IDLE) begin
      if (hit_clr) begin
        hit_cnt_d = CW'(0);
      end else if (hit_we && !hit_full_q) begin
        mem_we    = 1'b1;
        hit_cnt_d = hit_cnt_q + CW'(1);
      end
    end
    hit_full_d = (hit_cnt_d == CW'(MAX_HITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= 3'd0;
      ptr_q      <= PW'(0);
      wcnt_q     <= WW'(0);
      in_q       <= 8'd0;
      bomb_q     <= 8'd0;
      iv1_q      <= 1'b0;
      hit_q      <= 6'd0;
      iv2_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 7'd0;
      terr_q     <= 1'b0;
      hit_cnt_q  <= CW'(0);
      hit_full_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        board_in_q[i]   <= 8'd0;
        board_bomb_q[i] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      ptr_q      <= ptr_d;
      wcnt_q     <= wcnt_d;
      in_q       <= in_d;
      bomb_q     <= bomb_d;
      iv1_q      <= iv1_d;
      hit_q      <= hit_d;
      iv2_q      <= iv2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      terr_q     <= terr_d;
      hit_cnt_q  <= hit_cnt_d;
      hit_full_q <= hit_full_d;
      if (board_we) begin
        board_in_q[row_addr]   <= row_in;
        board_bomb_q[row_addr] <= row_bomb;
      end
    end
  end

  // Hit payload storage needs no reset: only entries below hit_cnt are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) hit_mem_q[AW'(hit_cnt_q)] <= hit_data;
  end

  assign ev.in        = in_q;
  assign ev.bomb      = bomb_q;
  assign ev.in_valid1 = iv1_q;
  assign ev.hit       = hit_q;
  assign ev.in_valid2 = iv2_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign timeout_err  = terr_q;
  assign hit_cnt      = hit_cnt_q;
  assign hit_full     = hit_full_q;

endmodule

// File: tb/tb_ot_board_tx.sv
// Self-checking bench for ot_board_tx against a transaction-level model of the board, hit list and timeline.
module tb_ot_board_tx;
  localparam int unsigned TMO  = 20;
  localparam int unsigned MAXH = 16;

  logic clk, rst_n;
  logic row_we, hit_we, hit_clr, start;
  logic [2:0] row_addr;
  logic [7:0] row_in, row_bomb;
  logic [5:0] hit_data;
  logic busy, done, timeout_err, hit_full;
  logic [6:0] result;
  logic [5:0] hit_cnt;

  ot_board_tx_if ev();

  ot_board_tx #(.MAX_HITS(MAXH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .row_we(row_we), .row_addr(row_addr), .row_in(row_in),
    .row_bomb(row_bomb), .hit_we(hit_we), .hit_data(hit_data), .hit_clr(hit_clr),
    .start(start), .ev(ev), .busy(busy), .done(done), .result(result),
    .timeout_err(timeout_err), .hit_cnt(hit_cnt), .hit_full(hit_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_in [8];
  logic [7:0] m_bomb [8];
  logic [5:0] m_hits [$];
  logic [6:0] m_result;
  logic       m_terr;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [40:0] get_obs();
    return {busy, done, ev.in_valid1, ev.in, ev.bomb, ev.in_valid2, ev.hit,
            result, timeout_err, hit_cnt, hit_full};
  endfunction

  function automatic logic [40:0] idle_exp();
    return {1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'h00, m_result, m_terr,
            6'(m_hits.size()), (m_hits.size() == MAXH)};
  endfunction

  task automatic model_clear_all();
    for (int i = 0; i < 8; i++) begin m_in[i] = 8'h00; m_bomb[i] = 8'h00; end
    m_hits.delete();
    m_result = 7'd0;
    m_terr   = 1'b0;
  endtask

  task automatic host_row(input logic [2:0] r, input logic [7:0] vi, input logic [7:0] vb);
    row_we = 1'b1; row_addr = r; row_in = vi; row_bomb = vb;
    m_in[r] = vi; m_bomb[r] = vb;
    @(negedge clk);
    row_we = 1'b0;
  endtask

  task automatic host_push(input logic [5:0] d);
    hit_we = 1'b1; hit_data = d;
    if (m_hits.size() < MAXH) m_hits.push_back(d);
    @(negedge clk);
    hit_we = 1'b0;
  endtask

  task automatic host_clr();
    hit_clr = 1'b1;
    m_hits.delete();
    @(negedge clk);
    hit_clr = 1'b0;
  endtask

  // Drives one transfer from a negedge; d<0 means the evaluator never answers,
  // otherwise out_valid is raised d cycles after WAIT begins.
  task automatic do_transfer(input string name, input int d, input logic [6:0] score,
                             input bit spurious, input bit poke);
    int n, last, resp_cyc;
    logic [40:0] exp_v, obs_v;
    logic e_v1, e_v2, e_done, e_busy, e_terr;
    logic [7:0] e_in, e_bomb;
    logic [5:0] e_hit;
    logic [6:0] e_res;
    n = m_hits.size();
    resp_cyc = 10 + n + d;
    last = (d < 0) ? 10 + n + int'(TMO) : 11 + n + d;
    start = 1'b1;
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      e_v1 = (j >= 1) && (j <= 8);
      e_in = 8'h00; e_bomb = 8'h00;
      if (e_v1) begin e_in = m_in[j-1]; e_bomb = m_bomb[j-1]; end
      e_v2 = (j >= 10) && (j <= 9 + n);
      e_hit = 6'h00;
      if (e_v2) e_hit = m_hits[j-10];
      e_done = (j == last);
      e_busy = (j < last);
      e_res  = e_done ? ((d < 0) ? 7'd0 : score) : m_result;
      e_terr = e_done && (d < 0);
      exp_v = {e_busy, e_done, e_v1, e_in, e_bomb, e_v2, e_hit, e_res, e_terr,
               6'(n), (n == MAXH)};
      obs_v = get_obs();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle T+%0d: got %h expected %h", name, j, obs_v, exp_v);
      end
      if (j == 1) start = 1'b0;
      ev.out_valid = (d >= 0) && (j == resp_cyc);
      ev.out = ev.out_valid ? score : 7'($urandom);
      if (spurious && j == 2) ev.out_valid = 1'b1;
      if (poke && j == 4) begin
        start = 1'b1; row_we = 1'b1; row_addr = 3'($urandom); row_in = 8'($urandom);
        row_bomb = 8'($urandom); hit_we = 1'b1; hit_data = 6'($urandom);
      end
      if (poke && j == 5) begin
        start = 1'b0; row_we = 1'b0; hit_we = 1'b0;
      end
      if (e_done) begin m_result = e_res; m_terr = e_terr; end
    end
    ev.out_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear_all();
    @(negedge clk);
    n_checks++;
    if (get_obs() !== idle_exp()) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", get_obs(), idle_exp());
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int r = 0; r < 8; r++) host_row(3'(r), 8'hFF >> r, 8'h01 << r);
    host_push(6'd0); host_push(6'd9); host_push(6'd63);
    do_transfer("basic", 1, 7'd42, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] s1, s2;
    s1 = 7'($urandom); s2 = 7'($urandom);
    do_transfer("busy_poke", int'($urandom_range(0, 4)), s1, 1'b0, 1'b1);
    do_transfer("replay", 0, s2, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    host_clr();
    host_push(6'($urandom));
    do_transfer("timeout", -1, 7'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (get_obs() !== idle_exp()) begin
        n_fail++;
        $display("FAIL timeout_sticky: got %h expected %h", get_obs(), idle_exp());
      end
    end
    do_transfer("after_timeout", int'($urandom_range(0, 3)), 7'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_buffer_full();
    host_clr();
    for (int k = 0; k < 17; k++) host_push(6'($urandom));
    n_checks++;
    if ({hit_cnt, hit_full} !== {6'd16, 1'b1}) begin
      n_fail++;
      $display("FAIL buffer_full: got cnt=%0d full=%b expected cnt=16 full=1", hit_cnt, hit_full);
    end
    do_transfer("full_transfer", int'($urandom_range(0, 5)), 7'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_random_board();
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < 8; r++) host_row(3'(r), 8'($urandom), 8'($urandom));
      host_clr();
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) host_push(6'($urandom));
      do_transfer("random", int'($urandom_range(0, 6)), 7'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_collision();
    host_push(6'($urandom));
    hit_clr = 1'b1; hit_we = 1'b1; hit_data = 6'($urandom);
    m_hits.delete();
    @(negedge clk);
    hit_clr = 1'b0; hit_we = 1'b0;
    n_checks++;
    if ({hit_cnt, hit_full} !== 7'd0) begin
      n_fail++;
      $display("FAIL clr_we_collision: got cnt=%0d full=%b expected cnt=0 full=0", hit_cnt, hit_full);
    end
  endtask

  task automatic test_reset_mid_send2();
    for (int k = 0; k < 3; k++) host_push(6'($urandom));
    start = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    model_clear_all();
    n_checks++;
    if (get_obs() !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", get_obs(), 41'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (get_obs() !== idle_exp()) begin
        n_fail++;
        $display("FAIL post_reset_idle: got %h expected %h", get_obs(), idle_exp());
      end
    end
  endtask

  task automatic test_empty_start();
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (get_obs() !== idle_exp()) begin
        n_fail++;
        $display("FAIL empty_start: got %h expected %h", get_obs(), idle_exp());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; row_we = 1'b0; hit_we = 1'b0; hit_clr = 1'b0; start = 1'b0;
    row_addr = 3'd0; row_in = 8'd0; row_bomb = 8'd0; hit_data = 6'd0;
    ev.out_valid = 1'b0; ev.out = 7'd0;
    test_reset();
    test_empty_start();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_buffer_full();
    test_random_board();
    test_collision();
    test_reset_mid_send2();
    test_empty_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
